pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_reconfig_ctrl_pkg.sv | 24 ++
 rtl/pll_sync2.sv | 14 +
 rtl/pll_reconfig_ctrl.sv | 111 +++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_ctrl_pkg.sv
// pll_reconfig_ctrl_pkg: controller states, counter-field encoding and shared constants
package pll_reconfig_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        WRITE,
        WAIT_DONE,
        UPDATE,
        WAIT_LOCK,
        FAIL
    } state_t;

    localparam int FIELD_W = 18;
    localparam int FAIL_HOLD = 16;
    localparam int TMR_W = 17;

    // {bypass, odd, high, low}; a divide of 1 is expressed as bypass only
    function automatic logic [FIELD_W-1:0] encode_field(input logic [7:0] v);
        return v == 8'd1 ? 18'h20000 : {1'b0, v[0], 8'((9'(v) + 9'd1) >> 1), v >> 1};
    endfunction

endpackage

// File: rtl/pll_sync2.sv
// pll_sync2: two-flop synchroniser for asynchronous PLL status inputs
module pll_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: serial reconfiguration of PLL N/M/C counters with scandone and lock handshakes
module pll_reconfig_ctrl
    import pll_reconfig_ctrl_pkg::*;
#(
    parameter int NUM_CLK = 1,
    parameter int DEFAULT_M = 1,
    parameter int DEFAULT_N = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_m,
    input  logic [7:0]           req_n,
    input  logic [8*NUM_CLK-1:0] req_c,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           cur_m,
    output logic [7:0]           cur_n,
    output logic                 pll_scanclk,
    output logic                 pll_scandata,
    output logic                 pll_scanwrite,
    output logic                 pll_configupdate,
    output logic                 pll_areset,
    input  logic                 pll_scandone,
    input  logic                 pll_locked
);
    localparam int L = FIELD_W * (2 + NUM_CLK);
    localparam logic [TMR_W-1:0] SHIFT_LAST = TMR_W'(2 * L - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(FAIL_HOLD - 1);

    state_t state, state_nx;
    logic [TMR_W-1:0] timer;
    logic [L-1:0] shreg, chain;
    logic [7:0] m_r, n_r;
    logic [8*NUM_CLK-1:0] c_r;
    logic bad, scandone_s, locked_s, areset_r;

    pll_sync2 u_sync_done (.clk(clk), .reset(reset), .d(pll_scandone), .q(scandone_s));
    pll_sync2 u_sync_lock (.clk(clk), .reset(reset), .d(pll_locked), .q(locked_s));

    always_comb begin
        bad = m_r == 8'd0 || n_r == 8'd0;
        chain = '0;
        chain[L-1 -: FIELD_W] = encode_field(n_r);
        chain[L-1-FIELD_W -: FIELD_W] = encode_field(m_r);
        for (int i = 0; i < NUM_CLK; i++) begin
            bad = bad || c_r[8*i +: 8] == 8'd0;
            chain[L-1-FIELD_W*(2+i) -: FIELD_W] = encode_field(c_r[8*i +: 8]);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = req_valid ? LOAD : IDLE;
            LOAD:      state_nx = bad ? IDLE : SHIFT;
            SHIFT:     state_nx = timer == SHIFT_LAST ? WRITE : SHIFT;
            WRITE:     state_nx = timer == TMR_W'(1) ? WAIT_DONE : WRITE;
            WAIT_DONE: state_nx = scandone_s ? UPDATE : timer >= WAIT_LAST ? FAIL : WAIT_DONE;
            UPDATE:    state_nx = WAIT_LOCK;
            WAIT_LOCK: state_nx = locked_s ? IDLE : timer >= WAIT_LAST ? FAIL : WAIT_LOCK;
            FAIL:      state_nx = timer == HOLD_LAST ? IDLE : FAIL;
            default:   state_nx = IDLE;
        endcase
    end

    // one timer serves shift pacing, write width, both waits and the FAIL hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            shreg <= '0;
            m_r <= '0;
            n_r <= '0;
            c_r <= '0;
            cur_m <= 8'(DEFAULT_M);
            cur_n <= 8'(DEFAULT_N);
            areset_r <= 1'b1;
        end else begin
            state <= state_nx;
            timer <= state_nx != state ? '0 : &timer ? timer : timer + TMR_W'(1);
            areset_r <= 1'b0;
            if (req_valid && req_ready) begin
                m_r <= req_m;
                n_r <= req_n;
                c_r <= req_c;
            end
            if (state == LOAD) shreg <= chain;
            else if (state == SHIFT && timer[0]) shreg <= shreg << 1;
            if (done) begin
                cur_m <= m_r;
                cur_n <= n_r;
            end
        end
    end

    // scanclk is high on odd shift cycles, so data only moves as scanclk falls
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == WAIT_LOCK && locked_s;
    assign err = (state == LOAD && bad) || (state == FAIL && timer == HOLD_LAST);
    assign pll_scanclk = state == SHIFT && timer[0];
    assign pll_scandata = state == SHIFT && shreg[L-1];
    assign pll_scanwrite = state == WRITE;
    assign pll_configupdate = state == UPDATE;
    assign pll_areset = areset_r || state == FAIL;
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: timeline reference model with per-cycle compare plus directed scenarios
module tb_pll_reconfig_ctrl;
    localparam int NC = 6, DEF_M = 5, DEF_N = 3, TO = 100;
    localparam int L = 18 * (2 + NC);
    localparam int NEVER = 1 << 30;

    logic clk = 0, reset = 1;
    always #5 clk = ~clk;

    logic req_valid = 0, req_ready, busy, done, err;
    logic scanclk, scandata, scanwrite, configupdate, areset;
    logic scandone = 0, locked = 0;
    logic [7:0] req_m = 0, req_n = 0, cur_m, cur_n;
    logic [8*NC-1:0] req_c = '0;

    pll_reconfig_ctrl #(.NUM_CLK(NC), .DEFAULT_M(DEF_M), .DEFAULT_N(DEF_N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_m(req_m), .req_n(req_n), .req_c(req_c), .busy(busy), .done(done), .err(err),
        .cur_m(cur_m), .cur_n(cur_n), .pll_scanclk(scanclk), .pll_scandata(scandata),
        .pll_scanwrite(scanwrite), .pll_configupdate(configupdate), .pll_areset(areset),
        .pll_scandone(scandone), .pll_locked(locked)
    );

    logic b_valid = 0, b_ready, b_busy, b_done, b_err, b_sclk, b_sdata, b_swrite, b_cfg, b_areset;
    logic b_sdone = 0, b_locked = 0;
    logic [7:0] b_cm, b_cn;

    pll_reconfig_ctrl dut_b (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
        .req_m(8'd10), .req_n(8'd1), .req_c(8'd3), .busy(b_busy), .done(b_done), .err(b_err),
        .cur_m(b_cm), .cur_n(b_cn), .pll_scanclk(b_sclk), .pll_scandata(b_sdata),
        .pll_scanwrite(b_swrite), .pll_configupdate(b_cfg), .pll_areset(b_areset),
        .pll_scandone(b_sdone), .pll_locked(b_locked)
    );

    int n_checks = 0, n_errors = 0;
    bit armed = 0;
    int mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] fld(input int v);
        return v == 1 ? 18'h20000 : 18'(((v % 2) << 16) | (((v + 1) / 2) << 8) | (v / 2));
    endfunction

    // Reference model: a transaction is a timeline indexed by k (cycles since accept)
    bit m_busy = 0, m_bad = 0, m_ok = 0, m_post_rst = 0;
    int k = 0, kend = 0, ks = NEVER, klk = NEVER, ku = -1, kf = -1, kdone = -1;
    logic [L-1:0] m_chain;
    logic [7:0] m_m, m_n, m_cm = DEF_M, m_cn = DEF_N;

    task automatic accept();
        int k0, kd, kl, klock;
        m_busy = 1;
        k = 0;
        m_m = req_m;
        m_n = req_n;
        m_bad = req_m == 0 || req_n == 0;
        m_chain = '0;
        m_chain[L-1 -: 18] = fld(req_n);
        m_chain[L-19 -: 18] = fld(req_m);
        for (int i = 0; i < NC; i++) begin
            m_bad = m_bad || req_c[8*i +: 8] == 0;
            m_chain[L-1-18*(2+i) -: 18] = fld(req_c[8*i +: 8]);
        end
        ks = NEVER;
        klk = NEVER;
        ku = -1;
        kf = -1;
        kdone = -1;
        if (m_bad) begin
            m_ok = 0;
            kend = 0;
            return;
        end
        k0 = 2 * L + 3;
        ks = mode != 0 ? k0 : $urandom_range(0, 7) == 0 ? NEVER : k0 - 3 + int'($urandom_range(0, 25));
        kd = ks + 2 > k0 ? ks + 2 : k0;
        if (kd - k0 > TO - 1) kf = k0 + TO;
        else begin
            ku = kd + 1;
            kl = ku + 1;
            klk = mode == 1 ? kl + 2 : mode == 2 ? NEVER :
                  $urandom_range(0, 7) == 0 ? NEVER : kl - 3 + int'($urandom_range(0, 25));
            klock = klk + 2 > kl ? klk + 2 : kl;
            if (klock - kl > TO - 1) kf = kl + TO;
            else kdone = klock;
        end
        m_ok = kdone >= 0;
        kend = m_ok ? kdone : kf + 15;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0;
            m_cm = DEF_M;
            m_cn = DEF_N;
            m_post_rst = 1;
        end else begin
            m_post_rst = 0;
            if (!m_busy) begin
                if (req_valid) accept();
            end else if (k == kend) begin
                m_busy = 0;
                if (m_ok) begin
                    m_cm = m_m;
                    m_cn = m_n;
                end
            end else k++;
        end
    end

    // PLL stand-in for dut: status inputs follow the planned timeline
    always @(posedge clk) begin
        #1;
        scandone = m_busy && k >= ks;
        locked = m_busy && k >= klk;
    end

    always @(negedge clk) begin : cmp
        logic sh, e_sclk, e_sdata, e_swr, e_cfg, e_ar, e_done, e_err;
        if (armed) begin
            sh = m_busy && k >= 1 && k <= 2 * L;
            e_sclk = sh && ((k - 1) % 2 == 1);
            e_sdata = sh ? m_chain[L-1-(k-1)/2] : 1'b0;
            e_swr = m_busy && !m_bad && (k == 2 * L + 1 || k == 2 * L + 2);
            e_cfg = m_busy && k == ku;
            e_ar = m_post_rst || (m_busy && kf >= 0 && k >= kf && k <= kf + 15);
            e_done = m_busy && k == kdone;
            e_err = m_busy && ((m_bad && k == 0) || (kf >= 0 && k == kf + 15));
            check("busy", busy, m_busy);
            check("req_ready", req_ready, !m_busy);
            check("scanclk", scanclk, e_sclk);
            check("scandata", scandata, e_sdata);
            check("scanwrite", scanwrite, e_swr);
            check("configupdate", configupdate, e_cfg);
            check("areset", areset, e_ar);
            check("done", done, e_done);
            check("err", err, e_err);
            check("cur_m", cur_m, m_cm);
            check("cur_n", cur_n, m_cn);
        end
    end

    task automatic wait_idle(input string name);
        int w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (m_busy && w < 3000);
        check(name, req_ready, 1);
    endtask

    task automatic send(input logic [7:0] m, input logic [7:0] n, input logic [8*NC-1:0] c);
        wait_idle("send_idle");
        req_valid = 1;
        req_m = m;
        req_n = n;
        req_c = c;
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    function automatic logic [7:0] rnd_field();
        int r = int'($urandom_range(0, 39));
        return r == 0 ? 8'd0 : r < 4 ? 8'd1 : r < 6 ? 8'd255 : 8'($urandom_range(2, 254));
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rises, cnt_ar, cnt_err, cnt_done, cnt_swr;
        logic prev, prev_d, sw_seen, seen;
        logic [63:0] cap;
        logic [L-1:0] capa;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        armed = 1;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cur_m", cur_m, 5);
        check("rst_cur_n", cur_n, 3);
        check("rst_areset_high", areset, 1);
        check("rst_b_cur_m", b_cm, 1);
        @(negedge clk);
        check("rst_areset_low", areset, 0);

        // NUM_CLK=1 encoding with a reactive PLL stand-in
        @(posedge clk);
        #1 b_valid = 1;
        @(posedge clk);
        #1 b_valid = 0;
        rises = 0; cap = '0; prev = 0; prev_d = 0; sw_seen = 0; seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (b_sclk && !prev) begin
                rises++;
                cap = {cap[62:0], b_sdata};
                check("b_data_stable", b_sdata, prev_d);
            end
            prev = b_sclk;
            prev_d = b_sdata;
            if (b_swrite) sw_seen = 1;
            else if (sw_seen) b_sdone = 1;
            if (b_cfg) b_locked = 1;
            if (b_done) seen = 1;
        end
        check("b_done_seen", seen, 1);
        check("b_rises", rises, 54);
        check("b_chain", cap, {10'd0, 18'h20000, 18'h00505, 18'h10201});
        @(negedge clk);
        check("b_cur_m", b_cm, 10);
        check("b_cur_n", b_cn, 1);
        b_sdone = 0;
        b_locked = 0;

        // NUM_CLK=6 chain C0..C5 = 1..6
        mode = 1;
        send(9, 2, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        rises = 0; prev = 0; seen = 0; capa = '0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (scanclk && !prev) begin
                rises++;
                capa = {capa[L-2:0], scandata};
            end
            prev = scanclk;
            if (done) seen = 1;
        end
        check("a_done_seen", seen, 1);
        check("a_rises", rises, 144);
        check("a_field_n", capa[L-1 -: 18], 18'h00101);
        check("a_field_m", capa[L-19 -: 18], 18'h10504);
        check("a_field_c0", capa[L-37 -: 18], 18'h20000);
        check("a_field_c4_c5", capa[35:0], {18'h10302, 18'h00303});
        @(negedge clk);
        check("a_cur_m", cur_m, 9);
        check("a_cur_n", cur_n, 2);

        // request arriving during WAIT_LOCK is dropped
        send(30, 4, {6{8'd3}});
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (configupdate) seen = 1;
        end
        check("ign_cfg_seen", seen, 1);
        @(posedge clk);
        #1 begin req_valid = 1; req_m = 20; req_n = 7; req_c = {6{8'd9}}; end
        repeat (3) @(posedge clk);
        #1 req_valid = 0;
        wait_idle("ign_idle");
        repeat (3) @(negedge clk);
        check("ign_busy", busy, 0);
        check("ign_cur_m", cur_m, 30);

        // lock never arrives
        mode = 2;
        send(4, 4, {6{8'd4}});
        cnt_ar = 0; cnt_err = 0; cnt_done = 0; seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            cnt_ar += int'(areset);
            cnt_err += int'(err);
            cnt_done += int'(done);
            if (req_ready) seen = 1;
        end
        check("lto_ready", seen, 1);
        check("lto_areset_cycles", cnt_ar, 16);
        check("lto_err_pulses", cnt_err, 1);
        check("lto_done", cnt_done, 0);
        check("lto_cur_m", cur_m, 30);

        // reset at the 20th scanclk rise
        mode = 1;
        send(11, 5, {6{8'd7}});
        rises = 0; prev = 0;
        for (int c = 0; c < 1000 && rises < 20; c++) begin
            @(negedge clk);
            if (scanclk && !prev) rises++;
            prev = scanclk;
        end
        check("mid_rises", rises, 20);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("mid_ready", req_ready, 1);
        check("mid_busy", busy, 0);
        check("mid_cur_m", cur_m, 5);
        cnt_swr = 0;
        repeat (20) begin
            @(negedge clk);
            cnt_swr += int'(scanwrite);
        end
        check("mid_scanwrite", cnt_swr, 0);

        // zero field rejected
        send(7, 0, {6{8'd2}});
        @(negedge clk);
        check("bad_err", err, 1);
        rises = 0;
        repeat (10) begin
            @(negedge clk);
            rises += int'(scanclk);
        end
        check("bad_scanclk", rises, 0);
        check("bad_cur_n", cur_n, 3);

        // randomized traffic, including requests while busy
        mode = 0;
        for (int c = 0; c < 14000; c++) begin
            @(posedge clk);
            #1;
            req_valid = $urandom_range(0, 15) == 0;
            req_m = rnd_field();
            req_n = rnd_field();
            for (int i = 0; i < NC; i++) req_c[8*i +: 8] = rnd_field();
        end
        req_valid = 0;
        wait_idle("final_idle");
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
